// File: rtl/pc_preemption_sequencer_if.sv
// Control-unit to PC/preemption sequencer bundle: decoded flow-control
// inputs plus the sequencer's PC, link and time-slice status outputs.
interface pc_preemption_sequencer_if #(
  parameter int PC_WIDTH    = 10,
  parameter int QUANT_WIDTH = 16
);
  logic                   Jump;
  logic                   JLink;
  logic                   JumpR;
  logic                   HLT;
  logic                   Finalize;
  logic                   PreempON;
  logic                   PreempOFF;
  logic                   BranchTaken;
  logic [15:0]            BranchOffset;
  logic [PC_WIDTH-1:0]    JumpTarget;
  logic [PC_WIDTH-1:0]    RegTarget;
  logic                   Continue;
  logic [PC_WIDTH-1:0]    PC;
  logic [PC_WIDTH-1:0]    LinkAddr;
  logic [PC_WIDTH-1:0]    SavedPC;
  logic                   Halted;
  logic                   Preempted;
  logic                   SliceArmed;
  logic [QUANT_WIDTH-1:0] SliceLeft;

  // Control unit / stimulus side
  modport master (
    output Jump, JLink, JumpR, HLT, Finalize, PreempON, PreempOFF,
           BranchTaken, BranchOffset, JumpTarget, RegTarget, Continue,
    input  PC, LinkAddr, SavedPC, Halted, Preempted, SliceArmed, SliceLeft
  );

  // Sequencer side
  modport slave (
    input  Jump, JLink, JumpR, HLT, Finalize, PreempON, PreempOFF,
           BranchTaken, BranchOffset, JumpTarget, RegTarget, Continue,
    output PC, LinkAddr, SavedPC, Halted, Preempted, SliceArmed, SliceLeft
  );
endinterface

// File: rtl/pc_preemption_sequencer.sv
// Program counter and time-slice preemption sequencer. Selects the next
// PC from the decoded flow-control signals, handles HLT/Continue, and traps
// an armed user process back to OS_ENTRY after QUANTUM instructions.
module pc_preemption_sequencer #(
  parameter int PC_WIDTH    = 10,
  parameter int QUANT_WIDTH = 16,
  parameter int QUANTUM     = 64,
  parameter int RESET_PC    = 0,
  parameter int OS_ENTRY    = 0
) (
  input logic                   clock,
  input logic                   reset,
  pc_preemption_sequencer_if.slave bus
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  localparam logic [PC_WIDTH-1:0]    PC_RST  = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0]    PC_OS   = PC_WIDTH'(OS_ENTRY);
  localparam logic [QUANT_WIDTH-1:0] Q_LOAD  = QUANT_WIDTH'(QUANTUM);
  localparam logic [QUANT_WIDTH-1:0] Q_ONE   = QUANT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    saved_q, saved_d;
  logic [QUANT_WIDTH-1:0] left_q, left_d;
  logic                   armed_q, armed_d;
  logic                   preempted_q, preempted_d;

  logic [PC_WIDTH-1:0]    pc_plus1;
  logic [PC_WIDTH-1:0]    off;
  logic [PC_WIDTH-1:0]    flow_pc;
  logic signed [31:0]     off_ext;
  logic                   slice_ctl;
  logic                   trap;

  // Offset is sign-extended (or truncated) to the PC width; PC math wraps.
  assign off_ext  = 32'(signed'(bus.BranchOffset));
  assign off      = off_ext[PC_WIDTH-1:0];
  assign pc_plus1 = pc_q + PC_WIDTH'(1);

  // Lower-priority flow target: also the resume address saved on a trap,
  // so a jump or branch in the expiring instruction is not lost.
  always_comb begin
    flow_pc = pc_plus1;
    if (bus.JumpR)                  flow_pc = bus.RegTarget;
    else if (bus.Jump || bus.JLink) flow_pc = bus.JumpTarget;
    else if (bus.BranchTaken)       flow_pc = pc_plus1 + off;
  end

  // Any of these suppress both the decrement and the expiry trap.
  assign slice_ctl = bus.PreempON | bus.PreempOFF | bus.HLT | bus.Finalize;
  assign trap      = armed_q && (left_q == Q_ONE) && !slice_ctl;

  // State and datapath registers; async active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      pc_q        <= PC_RST;
      saved_q     <= '0;
      left_q      <= '0;
      armed_q     <= 1'b0;
      preempted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      saved_q     <= saved_d;
      left_q      <= left_d;
      armed_q     <= armed_d;
      preempted_q <= preempted_d;
    end
  end

  // Next-state: PC priority chain in RUN, frozen in HALTED until Continue.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    saved_d     = saved_q;
    left_d      = left_q;
    armed_d     = armed_q;
    preempted_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.HLT) begin
          state_d = HALTED;
        end else if (bus.Finalize) begin
          pc_d    = PC_OS;
          armed_d = 1'b0;
        end else if (trap) begin
          saved_d     = flow_pc;
          pc_d        = PC_OS;
          armed_d     = 1'b0;
          left_d      = '0;
          preempted_d = 1'b1;
        end else begin
          pc_d = flow_pc;
          if (bus.PreempON) begin
            left_d  = Q_LOAD;
            armed_d = 1'b1;
          end else if (bus.PreempOFF) begin
            armed_d = 1'b0;
          end else if (armed_q && left_q > Q_ONE) begin
            left_d = left_q - Q_ONE;
          end
        end
      end
      HALTED: begin
        if (bus.Continue) begin
          pc_d    = pc_plus1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.PC         = pc_q;
  assign bus.LinkAddr   = pc_plus1;
  assign bus.SavedPC    = saved_q;
  assign bus.Halted     = (state_q == HALTED);
  assign bus.Preempted  = preempted_q;
  assign bus.SliceArmed = armed_q;
  assign bus.SliceLeft  = left_q;

endmodule

// File: tb/tb_pc_preemption_sequencer.sv
// Directed bench for pc_preemption_sequencer with QUANTUM=4.
module tb_pc_preemption_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  pc_preemption_sequencer_if #(.PC_WIDTH(10), .QUANT_WIDTH(16)) bus ();

  pc_preemption_sequencer #(
    .PC_WIDTH(10), .QUANT_WIDTH(16), .QUANTUM(4), .RESET_PC(0), .OS_ENTRY(0)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    bus.Jump = 0; bus.JLink = 0; bus.JumpR = 0; bus.HLT = 0;
    bus.Finalize = 0; bus.PreempON = 0; bus.PreempOFF = 0;
    bus.BranchTaken = 0; bus.BranchOffset = '0;
    bus.JumpTarget = '0; bus.RegTarget = '0; bus.Continue = 0;
  endtask

  task automatic jump_to(input int t);
    bus.Jump = 1; bus.JumpTarget = 10'(t);
    tick();
    bus.Jump = 0;
  endtask

  // Jump to 20, arm there, and run to PC=24 where SliceLeft==1.
  task automatic arm_to_expiry(input string tag);
    jump_to(20);
    bus.PreempON = 1;
    tick();
    bus.PreempON = 0;
    chk({tag, "_armed"}, int'(bus.SliceArmed), 1);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_pc"}, int'(bus.PC), 21 + i);
      chk({tag, "_left"}, int'(bus.SliceLeft), 4 - i);
      if (i < 3) tick();
    end
  endtask

  initial begin
    clr();
    repeat (2) @(posedge clock);
    #1;
    reset = 1;

    // Reset values, then free-running increment
    chk("rst_pc", int'(bus.PC), 0);
    chk("rst_saved", int'(bus.SavedPC), 0);
    chk("rst_halted", int'(bus.Halted), 0);
    chk("rst_preempted", int'(bus.Preempted), 0);
    chk("rst_armed", int'(bus.SliceArmed), 0);
    chk("rst_left", int'(bus.SliceLeft), 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("inc_pc", int'(bus.PC), i);
      chk("inc_halted", int'(bus.Halted), 0);
      chk("inc_preempted", int'(bus.Preempted), 0);
    end

    // Branch with negative offset, then JAL
    jump_to(10);
    chk("jmp_pc", int'(bus.PC), 10);
    bus.BranchTaken = 1; bus.BranchOffset = 16'hFFFD;
    tick();
    clr();
    chk("br_pc", int'(bus.PC), 8);
    bus.JLink = 1; bus.JumpTarget = 10'd200;
    #1;
    chk("jal_link", int'(bus.LinkAddr), 9);
    tick();
    clr();
    chk("jal_pc", int'(bus.PC), 200);

    // JumpR beats Jump, Jump beats branch
    bus.JumpR = 1; bus.RegTarget = 10'd77; bus.Jump = 1; bus.JumpTarget = 10'd5;
    bus.BranchTaken = 1; bus.BranchOffset = 16'd3;
    tick();
    chk("jr_prio", int'(bus.PC), 77);
    bus.JumpR = 0;
    tick();
    clr();
    chk("j_over_br", int'(bus.PC), 5);

    // Wrap from max to 0
    jump_to(1023);
    chk("wrap_max", int'(bus.PC), 1023);
    tick();
    chk("wrap_zero", int'(bus.PC), 0);

    // Time-slice expiry trap
    arm_to_expiry("trap");
    tick();
    chk("trap_pc", int'(bus.PC), 0);
    chk("trap_saved", int'(bus.SavedPC), 25);
    chk("trap_pulse", int'(bus.Preempted), 1);
    chk("trap_armed", int'(bus.SliceArmed), 0);
    chk("trap_left", int'(bus.SliceLeft), 0);
    tick();
    chk("trap_pulse_end", int'(bus.Preempted), 0);
    chk("trap_pc_after", int'(bus.PC), 1);

    // PreempOFF on the expiry cycle: no trap
    arm_to_expiry("off");
    bus.PreempOFF = 1;
    tick();
    clr();
    chk("off_pc", int'(bus.PC), 25);
    chk("off_preempted", int'(bus.Preempted), 0);
    chk("off_armed", int'(bus.SliceArmed), 0);
    chk("off_left", int'(bus.SliceLeft), 1);

    // HLT on the expiry cycle, Continue three cycles later
    arm_to_expiry("hlt");
    bus.HLT = 1;
    tick();
    chk("hlt_halted", int'(bus.Halted), 1);
    chk("hlt_left", int'(bus.SliceLeft), 1);
    for (int i = 0; i < 3; i++) begin
      chk("hlt_pc_hold", int'(bus.PC), 24);
      if (i < 2) tick();
    end
    bus.Continue = 1;
    tick();
    clr();
    chk("cont_pc", int'(bus.PC), 25);
    chk("cont_halted", int'(bus.Halted), 0);
    chk("cont_preempted", int'(bus.Preempted), 0);
    tick();
    chk("late_trap_pc", int'(bus.PC), 0);
    chk("late_trap_saved", int'(bus.SavedPC), 26);
    chk("late_trap_pulse", int'(bus.Preempted), 1);

    // Finalize while armed: OS entry, disarm, SavedPC untouched
    jump_to(40);
    bus.PreempON = 1;
    tick();
    bus.PreempON = 0;
    bus.Finalize = 1;
    tick();
    clr();
    chk("fin_pc", int'(bus.PC), 0);
    chk("fin_armed", int'(bus.SliceArmed), 0);
    chk("fin_saved", int'(bus.SavedPC), 26);

    // Async reset mid-slice while halted
    jump_to(20);
    bus.PreempON = 1;
    tick();
    bus.PreempON = 0;
    tick();
    tick();
    chk("ar_left_pre", int'(bus.SliceLeft), 2);
    bus.HLT = 1;
    tick();
    chk("ar_halted_pre", int'(bus.Halted), 1);
    #2;
    reset = 0;
    #1;
    chk("ar_pc", int'(bus.PC), 0);
    chk("ar_halted", int'(bus.Halted), 0);
    chk("ar_left", int'(bus.SliceLeft), 0);
    chk("ar_armed", int'(bus.SliceArmed), 0);
    chk("ar_saved", int'(bus.SavedPC), 0);
    chk("ar_preempted", int'(bus.Preempted), 0);
    clr();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
